// File: rtl/baud_arb_pkg.sv
// Shared types and constants for the baud-generator sharing arbiter.
package baud_arb_pkg;

    localparam int unsigned BAUD_CODE_MAX = 9;
    localparam int unsigned BAUD_SEL_W    = 4;
    localparam int unsigned HOLD_W        = 16;
    localparam int unsigned SETTLE_W      = 8;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ARB    = 3'd1,
        LOAD   = 3'd2,
        SETTLE = 3'd3,
        ACTIVE = 3'd4
    } arb_state_e;

    function automatic logic code_valid(input logic [BAUD_SEL_W-1:0] code);
        return (code <= BAUD_SEL_W'(BAUD_CODE_MAX));
    endfunction

endpackage

// File: rtl/baud_share_arbiter_rr_pick.sv
// Combinational round-robin picker: first asserted request at or after ptr,
// wrapping modulo N.
module rr_pick #(
    parameter int N     = 4,
    parameter int PTR_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     Req,
    input  logic [PTR_W-1:0] ptr,
    output logic             found,
    output logic [PTR_W-1:0] idx
);

    localparam logic [PTR_W:0] N_W = (PTR_W + 1)'(N);

    logic [N-1:0]   rot_s;
    logic [PTR_W:0] off_s;
    logic [PTR_W:0] sum_s;

    // Rotate so that bit 0 is the request at ptr, then take the lowest set bit.
    always_comb begin
        rot_s = N'({Req, Req} >> ptr);
        found = 1'b0;
        off_s = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (rot_s[k]) begin
                found = 1'b1;
                off_s = (PTR_W + 1)'(k);
            end else begin
                found = found;
            end
        end
        sum_s = {1'b0, ptr} + off_s;
        if (sum_s >= N_W) begin
            idx = PTR_W'(sum_s - N_W);
        end else begin
            idx = sum_s[PTR_W-1:0];
        end
    end

endmodule

// File: rtl/baud_share_arbiter.sv
// Arbitrates one baud-rate generator among N_REQ UART channels, re-initialising
// the generator on each ownership change and flagging when its clock is usable.
module baud_share_arbiter
    import baud_arb_pkg::*;
#(
    parameter int                  N_REQ         = 4,
    parameter logic [SETTLE_W-1:0] SETTLE_CYCLES = 8'd2,
    parameter logic [HOLD_W-1:0]   HOLD_MAX      = 16'd0
) (
    input  logic                  Clk,
    input  logic                  Reset_n,
    input  logic [N_REQ-1:0]      Req,
    input  logic [4*N_REQ-1:0]    Req_sel,
    output logic [N_REQ-1:0]      Grant,
    output logic                  Ready,
    output logic [N_REQ-1:0]      Err,
    output logic                  Busy,
    output logic [BAUD_SEL_W-1:0] Baud_select,
    output logic                  Gen_reset
);

    localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    arb_state_e            state_q, state_d;
    logic [PTR_W-1:0]      ptr_q, ptr_d;
    logic [SETTLE_W-1:0]   settle_q, settle_d;
    logic [HOLD_W-1:0]     hold_q, hold_d;
    logic [N_REQ-1:0]      req_q;
    logic [N_REQ-1:0]      grant_q, grant_d;
    logic [N_REQ-1:0]      err_q, err_d;
    logic                  ready_q, ready_d;
    logic                  busy_q, busy_d;
    logic                  gen_rst_q, gen_rst_d;
    logic [BAUD_SEL_W-1:0] sel_q, sel_d;

    logic                  pick_found_s;
    logic [PTR_W-1:0]      pick_idx_s;
    logic [PTR_W-1:0]      ptr_next_s;
    logic [BAUD_SEL_W-1:0] pick_code_s;
    logic                  pick_valid_s;
    logic [N_REQ-1:0]      pick_oh_s;
    logic [HOLD_W-1:0]     hold_inc_s;
    logic                  owner_req_s;
    logic                  others_req_s;
    logic                  hold_hit_s;

    rr_pick #(
        .N     (N_REQ),
        .PTR_W (PTR_W)
    ) u_pick (
        .Req   (Req),
        .ptr   (ptr_q),
        .found (pick_found_s),
        .idx   (pick_idx_s)
    );

    // Ownership checks use the registered Req, so a drop seen at one edge acts at the next.
    always_comb begin
        pick_code_s  = Req_sel[{pick_idx_s, 2'b00} +: BAUD_SEL_W];
        pick_valid_s = code_valid(pick_code_s);
        pick_oh_s    = N_REQ'(1'b1) << pick_idx_s;
        if (pick_idx_s == PTR_W'(N_REQ - 1)) begin
            ptr_next_s = '0;
        end else begin
            ptr_next_s = pick_idx_s + PTR_W'(1);
        end
        if (hold_q == {HOLD_W{1'b1}}) begin
            hold_inc_s = hold_q;
        end else begin
            hold_inc_s = hold_q + HOLD_W'(1);
        end
        owner_req_s  = |(req_q & grant_q);
        others_req_s = |(req_q & ~grant_q);
        hold_hit_s   = (HOLD_MAX != '0) && (hold_inc_s >= HOLD_MAX);
    end

    // State register.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (|Req) state_d = ARB;
                else      state_d = IDLE;
            end
            ARB: begin
                if (pick_found_s && pick_valid_s) state_d = LOAD;
                else                              state_d = IDLE;
            end
            LOAD: begin
                if (owner_req_s) state_d = SETTLE;
                else             state_d = IDLE;
            end
            SETTLE: begin
                if (!owner_req_s)                     state_d = IDLE;
                else if (settle_q <= SETTLE_W'(1))    state_d = ACTIVE;
                else                                  state_d = SETTLE;
            end
            ACTIVE: begin
                if (!owner_req_s || (hold_hit_s && others_req_s)) state_d = IDLE;
                else                                              state_d = ACTIVE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Output and counter next values, aligned with the state being entered.
    always_comb begin
        ptr_d    = ptr_q;
        settle_d = '0;
        hold_d   = '0;
        grant_d  = grant_q;
        sel_d    = sel_q;
        err_d    = '0;
        case (state_q)
            ARB: begin
                if (pick_found_s) begin
                    ptr_d = ptr_next_s;
                    if (pick_valid_s) begin
                        grant_d = pick_oh_s;
                        sel_d   = pick_code_s;
                    end else begin
                        err_d   = pick_oh_s;
                    end
                end else begin
                    ptr_d = ptr_q;
                end
            end
            LOAD:    settle_d = SETTLE_CYCLES;
            SETTLE:  settle_d = settle_q - SETTLE_W'(1);
            ACTIVE:  hold_d   = hold_inc_s;
            default: settle_d = '0;
        endcase
        if (state_d == IDLE) begin
            grant_d = '0;
        end else begin
            grant_d = grant_d;
        end
        ready_d   = (state_d == ACTIVE);
        busy_d    = (state_d != IDLE);
        gen_rst_d = (state_d == IDLE) || (state_d == ARB) || (state_d == LOAD);
    end

    // Datapath and output registers.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            ptr_q     <= '0;
            settle_q  <= '0;
            hold_q    <= '0;
            req_q     <= '0;
            grant_q   <= '0;
            err_q     <= '0;
            ready_q   <= 1'b0;
            busy_q    <= 1'b0;
            gen_rst_q <= 1'b1;
            sel_q     <= '0;
        end else begin
            ptr_q     <= ptr_d;
            settle_q  <= settle_d;
            hold_q    <= hold_d;
            req_q     <= Req;
            grant_q   <= grant_d;
            err_q     <= err_d;
            ready_q   <= ready_d;
            busy_q    <= busy_d;
            gen_rst_q <= gen_rst_d;
            sel_q     <= sel_d;
        end
    end

    assign Grant       = grant_q;
    assign Ready       = ready_q;
    assign Err         = err_q;
    assign Busy        = busy_q;
    assign Baud_select = sel_q;
    assign Gen_reset   = gen_rst_q;

endmodule

// File: tb/tb_baud_share_arbiter.sv
// Self-checking bench: directed scenarios plus randomized rounds scored against
// a round-robin reference model through an expected-event queue.
module tb_baud_share_arbiter;

    localparam int N      = 4;
    localparam int SETTLE = 2;

    logic        Clk;
    logic        Reset_n;
    logic [3:0]  Req;
    logic [15:0] Req_sel;
    logic [3:0]  Grant;
    logic        Ready;
    logic [3:0]  Err;
    logic        Busy;
    logic [3:0]  Baud_select;
    logic        Gen_reset;

    logic [3:0]  req_h;
    logic [15:0] sel_in_h;
    logic [3:0]  grant_h;
    logic        ready_h;
    logic [3:0]  err_h;
    logic        busy_h;
    logic [3:0]  sel_h;
    logic        gen_rst_h;

    int checks = 0;
    int errors = 0;
    bit mon_en = 1'b0;

    typedef struct {
        bit         is_err;
        int         idx;
        logic [3:0] code;
    } exp_t;
    exp_t exp_q[$];

    baud_share_arbiter dut (
        .Clk(Clk), .Reset_n(Reset_n), .Req(Req), .Req_sel(Req_sel),
        .Grant(Grant), .Ready(Ready), .Err(Err), .Busy(Busy),
        .Baud_select(Baud_select), .Gen_reset(Gen_reset)
    );

    baud_share_arbiter #(.N_REQ(4), .SETTLE_CYCLES(8'd2), .HOLD_MAX(16'd8)) dut_h (
        .Clk(Clk), .Reset_n(Reset_n), .Req(req_h), .Req_sel(sel_in_h),
        .Grant(grant_h), .Ready(ready_h), .Err(err_h), .Busy(busy_h),
        .Baud_select(sel_h), .Gen_reset(gen_rst_h)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(negedge Clk);
    endtask

    task automatic wait_ready(input string name);
        int b = 0;
        while (!Ready && b < 30) begin cyc(); b++; end
        chk(name, Ready, 1);
    endtask

    task automatic wait_idle(input string name);
        int b = 0;
        while ((Busy || Grant != 4'd0) && b < 60) begin cyc(); b++; end
        chk(name, Busy, 0);
    endtask

    // Monitor: pops the expected event on every grant rise or error pulse.
    initial begin
        logic [3:0] prev_grant = 4'd0;
        logic       prev_ready = 1'b0;
        int         since_grant = 0;
        logic [3:0] cur_code = 4'd0;
        logic [3:0] oh;
        exp_t       e;
        forever begin
            @(negedge Clk);
            if (mon_en) begin
                if (Err != 4'd0) begin
                    if (exp_q.size() == 0) begin
                        chk("mon_unexpected_err", Err, 0);
                    end else begin
                        e = exp_q.pop_front();
                        oh = 4'b0001 << e.idx;
                        chk("mon_err_kind", 32'(e.is_err), 1);
                        chk("mon_err_idx", Err, oh);
                        chk("mon_err_genrst", Gen_reset, 1);
                    end
                end
                if (Grant != 4'd0 && prev_grant == 4'd0) begin
                    if (exp_q.size() == 0) begin
                        chk("mon_unexpected_grant", Grant, 0);
                    end else begin
                        e = exp_q.pop_front();
                        oh = 4'b0001 << e.idx;
                        chk("mon_grant_kind", 32'(e.is_err), 0);
                        chk("mon_grant_idx", Grant, oh);
                        chk("mon_grant_code", Baud_select, e.code);
                        chk("mon_grant_genrst", Gen_reset, 1);
                        cur_code = e.code;
                    end
                    since_grant = 0;
                end else if (Grant != 4'd0) begin
                    since_grant++;
                end
                if (Ready && !prev_ready) begin
                    chk("mon_ready_latency", since_grant, SETTLE + 1);
                    chk("mon_ready_genrst", Gen_reset, 0);
                end
                if (Ready) chk("mon_ready_grant_stable", Grant, prev_grant);
                if (Grant != 4'd0) chk("mon_sel_latched", Baud_select, cur_code);
            end
            prev_grant = Grant;
            prev_ready = Ready;
        end
    end

    // Stimulus, directed scenarios and the randomized reference-model rounds.
    initial begin
        int         mptr;
        int         b;
        int         n;
        logic [3:0] mask;
        logic [3:0] rem;
        logic [3:0] codes[4];
        int         hold_len[4];
        int         hcnt[4];

        Reset_n = 1'b0; Req = 4'd0; Req_sel = 16'd0; req_h = 4'd0; sel_in_h = 16'd0;
        repeat (3) cyc();
        chk("rst_grant", Grant, 0);
        chk("rst_ready", Ready, 0);
        chk("rst_err", Err, 0);
        chk("rst_busy", Busy, 0);
        chk("rst_sel", Baud_select, 0);
        chk("rst_genrst", Gen_reset, 1);
        Reset_n = 1'b1;
        repeat (2) cyc();

        // Single request on channel 1, code 3.
        Req = 4'b0010; Req_sel = 16'h0030;
        cyc();
        chk("single_arb_grant", Grant, 0);
        chk("single_arb_busy", Busy, 1);
        cyc();
        chk("single_grant", Grant, 4'b0010);
        chk("single_sel", Baud_select, 3);
        chk("single_load_genrst", Gen_reset, 1);
        cyc();
        chk("single_settle_genrst", Gen_reset, 0);
        chk("single_settle_ready0", Ready, 0);
        cyc();
        chk("single_settle2_ready0", Ready, 0);
        cyc();
        chk("single_ready", Ready, 1);
        Req = 4'd0;
        cyc();
        chk("release_hold_grant", Grant, 4'b0010);
        cyc();
        chk("release_grant", Grant, 0);
        chk("release_ready", Ready, 0);
        chk("release_genrst", Gen_reset, 1);

        // Invalid code on channel 2, then ptr must start at 3.
        Req = 4'b0100; Req_sel = 16'h0C00;
        cyc();
        chk("inv_arb_err", Err, 0);
        cyc();
        chk("inv_err", Err, 4'b0100);
        chk("inv_grant", Grant, 0);
        chk("inv_genrst", Gen_reset, 1);
        Req = 4'd0;
        cyc();
        chk("inv_err_one_cycle", Err, 0);
        Req = 4'b1111; Req_sel = 16'h1111;
        cyc(); cyc();
        chk("inv_next_ptr", Grant, 4'b1000);
        Req = 4'd0;
        wait_idle("inv_idle");

        // Abort during SETTLE on channel 0.
        Req = 4'b0001; Req_sel = 16'h0004;
        cyc(); cyc();
        chk("abort_grant", Grant, 4'b0001);
        cyc();
        chk("abort_settle_genrst", Gen_reset, 0);
        Req = 4'd0;
        for (int i = 0; i < 6; i++) begin
            cyc();
            chk("abort_no_ready", Ready, 0);
        end
        chk("abort_grant_cleared", Grant, 0);
        chk("abort_genrst", Gen_reset, 1);

        // Asynchronous reset while ACTIVE.
        Req = 4'b0100; Req_sel = 16'h0200;
        wait_ready("async_pre_ready");
        chk("async_pre_grant", Grant, 4'b0100);
        @(posedge Clk); #3;
        Reset_n = 1'b0;
        #1;
        chk("async_grant", Grant, 0);
        chk("async_ready", Ready, 0);
        chk("async_genrst", Gen_reset, 1);
        chk("async_busy", Busy, 0);
        chk("async_sel", Baud_select, 0);
        Req = 4'b1000; Req_sel = 16'h6000;
        @(negedge Clk);
        Reset_n = 1'b1;
        cyc();
        chk("async_rel_ready", Ready, 0);
        chk("async_rel_err", Err, 0);
        cyc();
        chk("async_rel_grant", Grant, 4'b1000);
        Req = 4'd0;
        wait_idle("async_idle");
        mptr = 0;

        // Randomized rounds against the round-robin reference model.
        mon_en = 1'b1;
        for (int r = 0; r < 30; r++) begin
            mask = 4'($urandom_range(1, 15));
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(0, 4) == 0) codes[i] = 4'($urandom_range(10, 15));
                else                           codes[i] = 4'($urandom_range(0, 9));
                hold_len[i] = $urandom_range(1, 6);
                hcnt[i] = 0;
            end
            rem = mask;
            while (rem != 4'd0) begin
                for (int k = 0; k < N; k++) begin
                    if (rem[(mptr + k) % N]) begin
                        n = (mptr + k) % N;
                        break;
                    end
                end
                exp_q.push_back('{is_err: (codes[n] > 4'd9), idx: n, code: codes[n]});
                rem[n] = 1'b0;
                mptr = (n + 1) % N;
            end
            Req = mask;
            Req_sel = {codes[3], codes[2], codes[1], codes[0]};
            b = 0;
            while (Req != 4'd0 && b < 400) begin
                cyc();
                b++;
                for (int i = 0; i < N; i++) begin
                    if (Req[i]) begin
                        if (Err[i]) begin
                            Req[i] = 1'b0;
                        end else if (Grant[i] && Ready) begin
                            hcnt[i]++;
                            if (hcnt[i] >= hold_len[i]) Req[i] = 1'b0;
                            else Req_sel[4*i +: 4] = 4'($urandom_range(0, 15));
                        end
                    end
                end
            end
            chk("round_timeout", Req, 0);
            wait_idle("round_idle");
        end
        repeat (2) cyc();
        chk("scoreboard_empty", exp_q.size(), 0);
        mon_en = 1'b0;

        // Forced release on the HOLD_MAX=8 instance.
        req_h = 4'b0011; sel_in_h = 16'h0075;
        b = 0;
        while (!ready_h && b < 30) begin cyc(); b++; end
        chk("hold_first_ready", ready_h, 1);
        chk("hold_first_grant", grant_h, 4'b0001);
        n = 0; b = 0;
        while (grant_h == 4'b0001 && b < 60) begin n += 32'(ready_h); cyc(); b++; end
        chk("hold_ready_cycles0", n, 8);
        n = 0; b = 0;
        while (grant_h == 4'd0 && b < 20) begin n++; cyc(); b++; end
        chk("hold_gap_cycles", n, 2);
        chk("hold_second_grant", grant_h, 4'b0010);
        chk("hold_second_sel", sel_h, 7);
        b = 0;
        while (!ready_h && b < 30) begin cyc(); b++; end
        n = 0; b = 0;
        while (grant_h == 4'b0010 && b < 60) begin n += 32'(ready_h); cyc(); b++; end
        chk("hold_ready_cycles1", n, 8);
        req_h = 4'd0;
        repeat (8) cyc();
        chk("hold_idle_busy", busy_h, 0);
        chk("hold_idle_genrst", gen_rst_h, 1);
        chk("hold_no_err", err_h, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/baud_share_arbiter.md
# baud_share_arbiter

Shares the single baud-rate generator between up to `N_REQ` UART channels that each need a different rate. It arbitrates requests round-robin and drives the generator's `Baud_select` and `Reset` inputs. It re-initialises the generator on every ownership change and tells the grantee when the baud clock is usable. It sits between the UART channel controllers and the baud generator.

## Interface
- `N_REQ`, 4 — number of requesting channels (2..8)
- `SETTLE_CYCLES`, 2 — `Clk` cycles between generator reset release and `Ready`; range 1..255
- `HOLD_MAX`, 0 — max ACTIVE cycles before forced release when others wait; 0 = unlimited; 16-bit
- `Clk`  in  1  system clock, rising edge
- `Reset_n`  in  1  one clock; reset is asynchronous and active-low
- `Req`  in  `N_REQ`  level request per channel; held high for the whole ownership
- `Req_sel`  in  `4*N_REQ`  requested baud code per channel; channel i uses bits [4i+3:4i]
- `Grant`  out  `N_REQ`  one-hot owner, all-zero when unowned
- `Ready`  out  1  generator running with owner's code
- `Err`  out  `N_REQ`  one-cycle pulse: request rejected for invalid code
- `Busy`  out  1  state ≠ IDLE
- `Baud_select`  out  4  to generator select input
- `Gen_reset`  out  1  active-high, to generator `Reset`

## Operation
- Valid codes are 0..9; codes 10..15 are invalid.
- States and transitions:
  - **IDLE**: `Gen_reset`=1, `Grant`=0, `Ready`=0. Any `Req` high moves to ARB.
  - **ARB**, one cycle: round-robin pick. The search starts at index `ptr`, which is the last granted index +1 mod `N_REQ`, and takes the first `Req` high.
    - Invalid code: pulse `Err[i]`, set `ptr`=i+1, go to IDLE. The requester must drop and re-raise `Req`.
    - Valid code: register `Baud_select`=code and `Grant`=onehot(i), set `ptr`=i+1, go to LOAD.
    - No `Req` high (all dropped): go to IDLE.
  - **LOAD**, one cycle: `Gen_reset`=1 with the new `Baud_select` stable. Go to SETTLE, loading the settle counter with `SETTLE_CYCLES`.
  - **SETTLE**: `Gen_reset`=0. Decrement the counter; at 1, go to ACTIVE.
  - **ACTIVE**: `Ready`=1 and `Gen_reset`=0. The hold counter increments, saturating at its 16-bit maximum.
- Exits from ACTIVE:
  - `Req[owner]` low → IDLE.
  - `HOLD_MAX`≠0, hold counter ≥ `HOLD_MAX`, and any other `Req` high → IDLE (forced release).
- `Req[owner]` low during LOAD or SETTLE → abort to IDLE next cycle; no `Ready` pulse.
- `Req_sel[owner]` changes after ARB are ignored; the code stays latched until the next grant.
- The generator's reset clears only its output, not its divider count. The first half-period after `Ready` may therefore be short by up to one divider period. Grantees wait one baud edge before transmitting.
- A re-raised `Req` from the just-released owner has lowest priority in the next ARB.

## Timing
- Reset values:
  - `Grant`=0, `Ready`=0, `Err`=0, `Busy`=0
  - `Baud_select`=0, `Gen_reset`=1
  - `ptr`=0, state IDLE, both counters 0
- All outputs are registered.
- Latency: `Req` sampled high at edge t in IDLE → `Grant`/`Baud_select` valid after edge t+1 → `Ready` high after edge t+2+`SETTLE_CYCLES` (t+4 at default).
- Release: `Req[owner]` sampled low at edge u → `Grant`=0, `Ready`=0, `Gen_reset`=1 after edge u+1.
- Back-to-back owners: minimum 2+2+`SETTLE_CYCLES` cycles from one owner's release to the next `Ready` (IDLE, ARB, LOAD, SETTLE).
- `Err` is high exactly one cycle, in the cycle after ARB.
- `Reset_n` asserted mid-operation: all outputs return to reset values immediately (asynchronous), with no `Err` or `Ready` glitch on deassertion.

## Structure
- Package `baud_arb_pkg` holds:
  - state enum {IDLE, ARB, LOAD, SETTLE, ACTIVE}
  - `BAUD_CODE_MAX`=9
  - `BAUD_SEL_W`=4
- Sub-module `rr_pick`: combinational round-robin picker.
  - Inputs: `Req`, `ptr`.
  - Outputs: `found` and `idx`.
- The top level holds the FSM, the counters, and the output registers.

## Test plan
- Single request: `Req[1]`=1 with code 3 at edge 0 → `Grant`=0010 and `Baud_select`=3 after edge 1; `Gen_reset` high exactly through LOAD; `Ready`=1 after edge 4.
- Contention: `Req`=1111 held and each owner drops `Req` 20 cycles after `Ready` → grant order 0,1,2,3,0; `Ready` never high while `Grant` is changing.
- Invalid code: `Req[2]`=1 with code 12 → `Err`=0100 for one cycle; no `Grant`; `Gen_reset` stays 1; next ARB starts at index 3.
- Abort: `Req[0]` drops during SETTLE → IDLE next cycle; `Ready` never asserted; `Gen_reset`=1.
- Forced release with `HOLD_MAX`=8: owner 0 holds `Req` and `Req[1]`=1 → after 8 ACTIVE cycles `Grant` goes 0001→0000→0010.
- Async reset: `Reset_n` low in ACTIVE, mid-cycle → outputs return to reset values before the next edge; after release with `Req`=1000, channel 3 is granted (`ptr`=0 search).
